// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, PC-source and fetch-state encodings
// Contents:
//   R_TYPE, ADDI, BEQ, BNE, J   6-bit primary opcodes (instr[31:26])
//   pcsrc_e                     next-PC select encodings driven by the control FSM
//   fetch_state_e               instruction-fetch FSM states
//   jump_target()               pseudo-direct jump address build
package cpu_pkg;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] J      = 6'b000010;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  // Jump keeps the current 256 MB region and word-aligns the 26-bit index.
  function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] imm26);
    return {pc_hi, imm26, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ir_unit_if.sv
// rtl/pc_ir_unit_if.sv - instruction-memory req/ack bus
// Signals:
//   req    fetch request (from the fetch unit)
//   addr   fetch address, 32 bits (from the fetch unit)
//   rdata  instruction word, 32 bits (from memory)
//   ack    rdata valid this cycle (from memory)
// Modports: master = fetch unit side, slave = memory side.
interface pc_ir_unit_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output addr, input rdata, input ack);
  modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC select
// Ports:
//   pc_source   in   next-PC select from the control FSM
//   alu_result  in   32  live ALU output
//   alu_out     in   32  registered ALU output (branch target)
//   pc_hi       in   4   pc[31:28] for jump targets
//   jump_imm    in   26  instr[25:0]
//   next_pc     out  32  selected next PC
//   next_valid  out  1   0 for the reserved select: PC must hold
module pc_next_mux
  import cpu_pkg::*;
(
  input  pcsrc_e      pc_source,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [3:0]  pc_hi,
  input  logic [25:0] jump_imm,
  output logic [31:0] next_pc,
  output logic        next_valid
);

  always_comb begin
    next_pc    = alu_result;
    next_valid = 1'b1;
    case (pc_source)
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = jump_target(pc_hi, jump_imm);
      PCSRC_RSVD:   next_valid = 1'b0;
      default:      next_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// rtl/pc_ir_unit.sv - PC / IR / ALUOut registers with req/ack instruction fetch
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low
//   PCWrite      in   unconditional PC write enable
//   PCWriteCond  in   branch PC write enable (qualified by take)
//   PCSource     in   2  next-PC select
//   IRWrite      in   fetch request from the control FSM
//   alu_result   in   32 combinational ALU output
//   alu_zero     in   ALU zero flag
//   imem         master side of the instruction-memory bus
//   fetch_stall  out  control FSM must hold its state
//   fetch_err    out  sticky fetch-timeout flag
//   pc           out  32 program counter
//   instr        out  32 instruction register
//   opCode       out  6  instr[31:26]
//   alu_out      out  32 ALUOut register
//   fetch_count  out  CNT_W number of IR loads, wrapping
// Build option: define PCIR_BNE_EN to invert the branch condition for BNE.
module pc_ir_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic [1:0]       PCSource,
  input  logic             IRWrite,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  pc_ir_unit_if.master     imem,
  output logic             fetch_stall,
  output logic             fetch_err,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic [5:0]       opCode,
  output logic [31:0]      alu_out,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [31:0]       req_addr_q;
  logic [31:0]       next_pc;
  logic              next_valid;
  logic              take;
  logic              pc_en;
  logic              timeout;
  logic              ir_load;
  logic              ir_nop;
  logic              wait_start;

  assign opCode = instr[31:26];

`ifdef PCIR_BNE_EN
  assign take = (opCode == BNE) ? ~alu_zero : alu_zero;
`else
  assign take = alu_zero;
`endif

  // The fetch address is latched from pc, so pc must not move while waiting.
  assign pc_en   = (PCWrite | (PCWriteCond & take)) & (state_q == FETCH_IDLE);
  // An ack in the final wait cycle still wins over the timeout.
  assign timeout = (state_q == FETCH_WAIT) & ~imem.ack & (wait_cnt_q == WAIT_W'(MAX_WAIT));

  pc_next_mux u_next_mux (
    .pc_source  (pcsrc_e'(PCSource)),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .pc_hi      (pc[31:28]),
    .jump_imm   (instr[25:0]),
    .next_pc    (next_pc),
    .next_valid (next_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: if (IRWrite && !imem.ack) state_d = FETCH_WAIT;
      FETCH_WAIT: if (imem.ack || timeout) state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  always_comb begin
    imem.req    = 1'b0;
    imem.addr   = pc;
    fetch_stall = 1'b0;
    ir_load     = 1'b0;
    ir_nop      = 1'b0;
    wait_start  = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        imem.req    = IRWrite;
        imem.addr   = pc;
        fetch_stall = IRWrite & ~imem.ack;
        ir_load     = IRWrite & imem.ack;
        wait_start  = IRWrite & ~imem.ack;
      end
      FETCH_WAIT: begin
        imem.req    = 1'b1;
        imem.addr   = req_addr_q;
        fetch_stall = ~imem.ack & ~timeout;
        ir_load     = imem.ack;
        ir_nop      = timeout;
      end
      default: begin
        imem.req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      alu_out     <= 32'h0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
      wait_cnt_q  <= '0;
      req_addr_q  <= 32'h0;
    end else begin
      alu_out <= alu_result;

      if (pc_en && next_valid) begin
        pc <= next_pc;
      end

      if (ir_load) begin
        instr       <= imem.rdata;
        fetch_count <= fetch_count + CNT_W'(1);
      end else if (ir_nop) begin
        instr     <= 32'h0;
        fetch_err <= 1'b1;
      end

      // The counter holds the index of the current wait cycle, starting at 1.
      if (wait_start) begin
        req_addr_q <= pc;
        wait_cnt_q <= WAIT_W'(1);
      end else if ((state_q == FETCH_WAIT) && !imem.ack && !timeout) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb/tb_pc_ir_unit.sv - self-checking bench for pc_ir_unit
module tb_pc_ir_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 15;
  localparam int          CNT_W    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, PCWrite, PCWriteCond, IRWrite, alu_zero;
  logic [1:0]       PCSource;
  logic [31:0]      alu_result;
  logic             fetch_stall, fetch_err;
  logic [31:0]      pc, instr, alu_out;
  logic [5:0]       opCode;
  logic [CNT_W-1:0] fetch_count;

  pc_ir_unit_if imem_bus ();

  pc_ir_unit #(
    .RESET_PC (RESET_PC),
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .IRWrite     (IRWrite),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .imem        (imem_bus),
    .fetch_stall (fetch_stall),
    .fetch_err   (fetch_err),
    .pc          (pc),
    .instr       (instr),
    .opCode      (opCode),
    .alu_out     (alu_out),
    .fetch_count (fetch_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural state plus "busy waiting on memory" bookkeeping.
  logic [31:0]      m_pc = 0, m_instr = 0, m_aluout = 0, m_addr = 0;
  logic             m_err = 0, m_busy = 0;
  int               m_wcyc = 0;
  logic [CNT_W-1:0] m_cnt = 0;

  logic [5:0] ops [5] = '{R_TYPE, ADDI, BEQ, BNE, J};

  function automatic logic m_take();
`ifdef PCIR_BNE_EN
    return (m_instr[31:26] == BNE) ? !alu_zero : alu_zero;
`else
    return alu_zero;
`endif
  endfunction

  function automatic logic e_req();
    return m_busy ? 1'b1 : IRWrite;
  endfunction

  function automatic logic [31:0] e_addr();
    return m_busy ? m_addr : m_pc;
  endfunction

  function automatic logic e_stall();
    if (!m_busy) return IRWrite && !imem_bus.ack;
    return !imem_bus.ack && (m_wcyc != MAX_WAIT);
  endfunction

  task automatic model_step();
    logic [31:0] old_pc, old_instr, old_alu;
    old_pc = m_pc; old_instr = m_instr; old_alu = m_aluout;
    if (!reset) begin
      m_pc = RESET_PC; m_instr = 0; m_aluout = 0; m_err = 0; m_cnt = 0; m_busy = 0; m_wcyc = 0;
    end else begin
      m_aluout = alu_result;
      if ((PCWrite || (PCWriteCond && m_take())) && !m_busy) begin
        case (PCSource)
          2'd0: m_pc = alu_result;
          2'd1: m_pc = old_alu;
          2'd2: m_pc = {old_pc[31:28], old_instr[25:0], 2'b00};
          default: m_pc = old_pc;
        endcase
      end
      if (!m_busy) begin
        if (IRWrite && imem_bus.ack) begin
          m_instr = imem_bus.rdata; m_cnt = m_cnt + 1'b1;
        end else if (IRWrite) begin
          m_busy = 1; m_addr = old_pc; m_wcyc = 1;
        end
      end else if (imem_bus.ack) begin
        m_instr = imem_bus.rdata; m_cnt = m_cnt + 1'b1; m_busy = 0;
      end else if (m_wcyc == MAX_WAIT) begin
        m_instr = 0; m_err = 1; m_busy = 0;
      end else begin
        m_wcyc++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    PCWrite = 0; PCWriteCond = 0; PCSource = PCSRC_ALU; IRWrite = 0;
    alu_zero = 0; imem_bus.ack = 0;
  endtask

  task automatic test_reset();
    reset = 0; set_idle(); alu_result = 32'hDEAD_BEEF; imem_bus.rdata = 32'h1234_5678;
    tick(); tick();
    n_checks += 7;
    if (pc !== RESET_PC) begin n_errors++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    if (alu_out !== 32'h0) begin n_errors++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
    if (fetch_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    if (fetch_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    if (imem_bus.req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", imem_bus.req); end
    if (fetch_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", fetch_stall); end
  endtask

  task automatic test_zero_wait();
    reset = 1; alu_result = 0; IRWrite = 1; imem_bus.ack = 1; imem_bus.rdata = 32'h2008_0005;
    #1;
    n_checks += 3;
    if (fetch_stall !== 1'b0) begin n_errors++; $display("FAIL zw_stall: got %b want 0", fetch_stall); end
    if (imem_bus.req !== 1'b1) begin n_errors++; $display("FAIL zw_req: got %b want 1", imem_bus.req); end
    if (imem_bus.addr !== 32'h0) begin n_errors++; $display("FAIL zw_addr: got %h want 0", imem_bus.addr); end
    tick(); set_idle();
    n_checks += 3;
    if (instr !== 32'h2008_0005) begin n_errors++; $display("FAIL zw_instr: got %h want 20080005", instr); end
    if (opCode !== 6'h08) begin n_errors++; $display("FAIL zw_opcode: got %h want 08", opCode); end
    if (fetch_count !== 16'd1) begin n_errors++; $display("FAIL zw_count: got %0d want 1", fetch_count); end
  endtask

  task automatic test_wait_fetch();
    logic [31:0] data, start_pc;
    int stalls;
    data = $urandom; start_pc = 32'h0; stalls = 0;
    IRWrite = 1; imem_bus.ack = 0; imem_bus.rdata = data;
    #1;
    if (fetch_stall === 1'b1) stalls++;
    tick();
    IRWrite = 0; PCWrite = 1; PCSource = PCSRC_ALU;
    for (int i = 1; i <= 3; i++) begin
      alu_result = $urandom | 32'h10;
      imem_bus.ack = (i == 3);
      #1;
      if (fetch_stall === 1'b1) stalls++;
      n_checks += 2;
      if (imem_bus.addr !== start_pc) begin n_errors++; $display("FAIL wf_addr%0d: got %h want %h", i, imem_bus.addr, start_pc); end
      if (imem_bus.req !== 1'b1) begin n_errors++; $display("FAIL wf_req%0d: got %b want 1", i, imem_bus.req); end
      tick();
      n_checks++;
      if (pc !== start_pc) begin n_errors++; $display("FAIL wf_pc_held%0d: got %h want %h", i, pc, start_pc); end
    end
    set_idle();
    n_checks += 3;
    if (stalls != 3) begin n_errors++; $display("FAIL wf_stall_cycles: got %0d want 3", stalls); end
    if (instr !== data) begin n_errors++; $display("FAIL wf_instr: got %h want %h", instr, data); end
    if (fetch_count !== 16'd2) begin n_errors++; $display("FAIL wf_count: got %0d want 2", fetch_count); end
  endtask

  task automatic load_instr(input logic [31:0] word);
    IRWrite = 1; imem_bus.ack = 1; imem_bus.rdata = word;
    tick();
    IRWrite = 0; imem_bus.ack = 0;
  endtask

  task automatic test_jump();
    PCWrite = 1; PCSource = PCSRC_ALU; alu_result = 32'h40; tick(); PCWrite = 0;
    load_instr({J, 26'h10});
    PCWrite = 1; PCSource = PCSRC_JUMP; tick(); PCWrite = 0;
    n_checks++;
    if (pc !== 32'h0000_0040) begin n_errors++; $display("FAIL jump_a: got %h want 00000040", pc); end
    PCWrite = 1; PCSource = PCSRC_ALU; alu_result = 32'hA000_0000; tick(); PCWrite = 0;
    load_instr({J, 26'h3FF_FFFF});
    PCWrite = 1; PCSource = PCSRC_JUMP; tick();
    n_checks++;
    if (pc !== 32'hAFFF_FFFC) begin n_errors++; $display("FAIL jump_b: got %h want afffffc", pc); end
    PCSource = PCSRC_RSVD; alu_result = 32'h5555_0000; tick(); PCWrite = 0;
    n_checks++;
    if (pc !== 32'hAFFF_FFFC) begin n_errors++; $display("FAIL pcsrc_rsvd: got %h want afffffc", pc); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_a, exp_b;
    load_instr({BEQ, 26'h0});
    alu_result = 32'h80; tick();
    PCWriteCond = 1; PCSource = PCSRC_ALUOUT; alu_zero = 1; alu_result = 32'h1234; tick();
    n_checks++;
    if (pc !== 32'h80) begin n_errors++; $display("FAIL beq_taken: got %h want 80", pc); end
    PCWriteCond = 0; PCWrite = 1; PCSource = PCSRC_ALU; alu_result = 32'h200; tick(); PCWrite = 0;
    alu_result = 32'h80; tick();
    PCWriteCond = 1; PCSource = PCSRC_ALUOUT; alu_zero = 0; tick();
    n_checks++;
    if (pc !== 32'h200) begin n_errors++; $display("FAIL beq_not_taken: got %h want 200", pc); end
    PCWriteCond = 0; alu_result = 32'h80;
    load_instr({BNE, 26'h0});
`ifdef PCIR_BNE_EN
    exp_a = 32'h200; exp_b = 32'h300;
`else
    exp_a = 32'h80;  exp_b = 32'h80;
`endif
    PCWriteCond = 1; PCSource = PCSRC_ALUOUT; alu_zero = 1; alu_result = 32'h300; tick();
    n_checks++;
    if (pc !== exp_a) begin n_errors++; $display("FAIL bne_zero1: got %h want %h", pc, exp_a); end
    alu_zero = 0; alu_result = 32'h444; tick();
    n_checks++;
    if (pc !== exp_b) begin n_errors++; $display("FAIL bne_zero0: got %h want %h", pc, exp_b); end
    set_idle();
  endtask

  task automatic test_timeout();
    logic [31:0] data;
    logic [CNT_W-1:0] cnt0;
    IRWrite = 1; imem_bus.ack = 0; tick(); IRWrite = 0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      #1;
      n_checks++;
      if (fetch_stall !== (i != MAX_WAIT)) begin n_errors++; $display("FAIL to_stall%0d: got %b want %b", i, fetch_stall, (i != MAX_WAIT)); end
      tick();
    end
    n_checks += 3;
    if (instr !== 32'h0) begin n_errors++; $display("FAIL to_instr: got %h want 0", instr); end
    if (fetch_err !== 1'b1) begin n_errors++; $display("FAIL to_err: got %b want 1", fetch_err); end
    if (imem_bus.req !== 1'b0) begin n_errors++; $display("FAIL to_idle_req: got %b want 0", imem_bus.req); end
    data = $urandom;
    IRWrite = 1; imem_bus.rdata = data; tick();
    IRWrite = 0; imem_bus.ack = 1; tick(); imem_bus.ack = 0;
    n_checks += 2;
    if (instr !== data) begin n_errors++; $display("FAIL after_to_instr: got %h want %h", instr, data); end
    if (fetch_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b want 1", fetch_err); end
    cnt0 = fetch_count; data = $urandom; imem_bus.rdata = data;
    IRWrite = 1; tick(); IRWrite = 0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      imem_bus.ack = (i == MAX_WAIT);
      #1;
      tick();
    end
    imem_bus.ack = 0;
    n_checks += 2;
    if (instr !== data) begin n_errors++; $display("FAIL ack_at_limit: got %h want %h", instr, data); end
    if (fetch_count !== cnt0 + 1'b1) begin n_errors++; $display("FAIL ack_at_limit_count: got %0d want %0d", fetch_count, cnt0 + 1'b1); end
  endtask

  task automatic test_reset_mid_wait();
    alu_result = 32'h7777_0000; IRWrite = 1; imem_bus.ack = 0; tick(); tick(); tick();
    reset = 0; IRWrite = 0; tick();
    n_checks += 5;
    if (pc !== RESET_PC) begin n_errors++; $display("FAIL rmw_pc: got %h want %h", pc, RESET_PC); end
    if (instr !== 32'h0) begin n_errors++; $display("FAIL rmw_instr: got %h want 0", instr); end
    if (alu_out !== 32'h0) begin n_errors++; $display("FAIL rmw_alu_out: got %h want 0", alu_out); end
    if (fetch_err !== 1'b0) begin n_errors++; $display("FAIL rmw_err: got %b want 0", fetch_err); end
    if (fetch_count !== '0) begin n_errors++; $display("FAIL rmw_count: got %0d want 0", fetch_count); end
    reset = 1; imem_bus.ack = 1; imem_bus.rdata = 32'hCAFE_F00D;
    #1;
    n_checks += 2;
    if (imem_bus.req !== 1'b0) begin n_errors++; $display("FAIL rmw_req: got %b want 0", imem_bus.req); end
    if (fetch_stall !== 1'b0) begin n_errors++; $display("FAIL rmw_stall: got %b want 0", fetch_stall); end
    tick(); imem_bus.ack = 0;
    n_checks += 2;
    if (instr !== 32'h0) begin n_errors++; $display("FAIL late_ack_instr: got %h want 0", instr); end
    if (fetch_count !== '0) begin n_errors++; $display("FAIL late_ack_count: got %0d want 0", fetch_count); end
  endtask

  task automatic test_random();
    logic [31:0] word;
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) != 0);
      PCWrite     = ($urandom_range(0, 3) == 0);
      PCWriteCond = ($urandom_range(0, 3) == 0);
      PCSource    = 2'($urandom_range(0, 3));
      IRWrite     = $urandom_range(0, 1);
      alu_result  = $urandom;
      alu_zero    = $urandom_range(0, 1);
      imem_bus.ack = ((c / 100) % 2 == 1) ? ($urandom_range(0, 7) == 0) : $urandom_range(0, 1);
      word = $urandom;
      word[31:26] = ops[$urandom_range(0, 4)];
      imem_bus.rdata = word;
      #1;
      n_checks += 3;
      if (imem_bus.req !== e_req()) begin n_errors++; $display("FAIL rnd_req c%0d: got %b want %b", c, imem_bus.req, e_req()); end
      if (imem_bus.addr !== e_addr()) begin n_errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_bus.addr, e_addr()); end
      if (fetch_stall !== e_stall()) begin n_errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, fetch_stall, e_stall()); end
      tick();
      n_checks += 6;
      if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc c%0d: got %h want %h", c, pc, m_pc); end
      if (instr !== m_instr) begin n_errors++; $display("FAIL rnd_instr c%0d: got %h want %h", c, instr, m_instr); end
      if (opCode !== m_instr[31:26]) begin n_errors++; $display("FAIL rnd_opcode c%0d: got %h want %h", c, opCode, m_instr[31:26]); end
      if (alu_out !== m_aluout) begin n_errors++; $display("FAIL rnd_alu_out c%0d: got %h want %h", c, alu_out, m_aluout); end
      if (fetch_err !== m_err) begin n_errors++; $display("FAIL rnd_err c%0d: got %b want %b", c, fetch_err, m_err); end
      if (fetch_count !== m_cnt) begin n_errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, fetch_count, m_cnt); end
    end
    reset = 1; set_idle();
  endtask

  initial begin
    reset = 0; set_idle(); alu_result = 0; imem_bus.rdata = 0;
    test_reset();
    test_zero_wait();
    test_wait_fetch();
    test_jump();
    test_branch();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
